// File: rtl/multiplicador_seq8x8.sv
// -----------------------------------------------------------------------------
// multiplicador_seq8x8
//
// Sequential shift-and-add unit that rebuilds a dividend from a division
// result: a = q*b + r.  It is the inverse companion of the combinational 8x8
// divider in the RPN ALU.  It serves the ALU multiply operation (r = 0) and
// also checks that a quotient/remainder pair is consistent with its divisor.
//
// One operation at a time, start/busy/done handshake, N iteration cycles.
//
// Ports
//   clk    in   1    system clock, rising edge
//   rst_n  in   1    asynchronous reset, active-low
//   start  in   1    request; accepted in IDLE (and on the FIM exit edge)
//   q      in   N    quotient / multiplier
//   b      in   N    divisor / multiplicand
//   r      in   N    remainder / addend
//   a      out  2N   registered result q*b+r
//   ovf    out  1    result does not fit N bits (a[2N-1:N] != 0)
//   e      out  1    captured b was zero
//   rinv   out  1    captured b != 0 and r >= b (inconsistent remainder)
//   busy   out  1    high while iterating (exactly N cycles)
//   done   out  1    one-cycle pulse, result valid
// -----------------------------------------------------------------------------
module multiplicador_seq8x8 #(
   parameter int N = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [N-1:0]     q,
   input  logic [N-1:0]     b,
   input  logic [N-1:0]     r,
   output logic [2*N-1:0]   a,
   output logic             ovf,
   output logic             e,
   output logic             rinv,
   output logic             busy,
   output logic             done
);

   localparam int            CW       = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIM  = 2'd2
   } state_t;

   state_t            state_r;
   logic [2*N-1:0]    acc_r;
   logic [2*N-1:0]    mcand_r;
   logic [N-1:0]      mplier_r;
   logic [CW-1:0]     cnt_r;

   logic [2*N-1:0]    acc_sum_s;
   logic              accept_s;
   logic              b_zero_s;
   logic              r_inv_s;

   // Partial-product step: add the shifted multiplicand when the current
   // multiplier bit is set. Max q*b+r = 65280 for N=8, so 2N bits never wrap.
   always_comb begin
      acc_sum_s = acc_r;
      if (mplier_r[0]) begin
         acc_sum_s = acc_r + mcand_r;
      end else begin
         acc_sum_s = acc_r;
      end
   end

   // The FIM exit edge also accepts a new request so a held start yields one
   // operation every N+1 cycles; start during CALC is never queued.
   assign accept_s = start && ((state_r == IDLE) || (state_r == FIM));
   assign b_zero_s = (b == {N{1'b0}});
   assign r_inv_s  = (!b_zero_s) && (r >= b);

   // Control FSM with datapath registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         acc_r    <= {(2*N){1'b0}};
         mcand_r  <= {(2*N){1'b0}};
         mplier_r <= {N{1'b0}};
         cnt_r    <= {CW{1'b0}};
         a        <= {(2*N){1'b0}};
         ovf      <= 1'b0;
         e        <= 1'b0;
         rinv     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state_r)
            IDLE, FIM: begin
               done <= 1'b0;
               if (accept_s) begin
                  acc_r    <= {{N{1'b0}}, r};
                  mcand_r  <= {{N{1'b0}}, b};
                  mplier_r <= q;
                  cnt_r    <= {CW{1'b0}};
                  e        <= b_zero_s;
                  rinv     <= r_inv_s;
                  busy     <= 1'b1;
                  state_r  <= CALC;
               end else begin
                  busy     <= 1'b0;
                  state_r  <= IDLE;
               end
            end

            CALC: begin
               acc_r    <= acc_sum_s;
               mcand_r  <= mcand_r << 1;
               mplier_r <= mplier_r >> 1;
               cnt_r    <= cnt_r + CNT_ONE;
               if (cnt_r == CNT_LAST) begin
                  // Last iteration: publish the final sum directly.
                  a       <= acc_sum_s;
                  ovf     <= (acc_sum_s[2*N-1:N] != {N{1'b0}});
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_r <= FIM;
               end else begin
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  state_r <= CALC;
               end
            end

            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multiplicador_seq8x8.sv
module tb_multiplicador_seq8x8;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  q;
   logic [7:0]  b;
   logic [7:0]  r;
   logic [15:0] a;
   logic        ovf;
   logic        e;
   logic        rinv;
   logic        busy;
   logic        done;

   int n_checks;
   int n_fail;
   int n_ops;
   int n_dones;

   multiplicador_seq8x8 #(.N(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .q     (q),
      .b     (b),
      .r     (r),
      .a     (a),
      .ovf   (ovf),
      .e     (e),
      .rinv  (rinv),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issue one operation from IDLE and collect what the DUT shows.
   task automatic do_op(input logic [7:0] qi, input logic [7:0] bi, input logic [7:0] ri,
                        output int busy_cnt, output bit done_seen, output bit done_long,
                        output logic [15:0] a_o, output logic ovf_o, output logic e_o,
                        output logic rinv_o, output logic e_early);
      @(negedge clk);
      q = qi; b = bi; r = ri; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      q = ~qi; b = ~bi; r = ri ^ 8'hA5;   // operands may change after acceptance
      n_ops++;
      busy_cnt = 0; done_seen = 1'b0; done_long = 1'b0;
      a_o = 16'd0; ovf_o = 1'b0; e_o = 1'b0; rinv_o = 1'b0; e_early = 1'b0;
      for (int i = 0; i < 20 && !done_seen; i++) begin
         @(negedge clk);
         if (i == 0) e_early = e;
         if (busy) busy_cnt++;
         if (done) begin
            done_seen = 1'b1;
            n_dones++;
            a_o = a; ovf_o = ovf; e_o = e; rinv_o = rinv;
         end
      end
      @(negedge clk);
      done_long = done;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; q = 8'd0; b = 8'd0; r = 8'd0;
      repeat (3) @(negedge clk);
      n_checks++; if (a !== 16'd0) begin n_fail++; $display("FAIL reset_a: got %0d expected 0", a); end
      n_checks++; if ({ovf, e, rinv, busy, done} !== 5'b00000) begin n_fail++; $display("FAIL reset_flags: got %b expected 00000", {ovf, e, rinv, busy, done}); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int bc; bit ds, dl; logic [15:0] ao; logic ov, eo, ri, ee;
      do_op(8'd25, 8'd7, 8'd3, bc, ds, dl, ao, ov, eo, ri, ee);
      n_checks++; if (bc !== 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 8", bc); end
      n_checks++; if (ds !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %0d expected 1", ds); end
      n_checks++; if (dl !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse_len: got %0d expected 0", dl); end
      n_checks++; if (ao !== 16'd178) begin n_fail++; $display("FAIL basic_a: got %0d expected 178", ao); end
      n_checks++; if ({ov, eo, ri} !== 3'b000) begin n_fail++; $display("FAIL basic_flags: got %b expected 000", {ov, eo, ri}); end
      // Result is held while idle with different inputs present.
      q = 8'd9; b = 8'd9; r = 8'd9;
      repeat (4) @(negedge clk);
      n_checks++; if (a !== 16'd178) begin n_fail++; $display("FAIL basic_hold_a: got %0d expected 178", a); end
   endtask

   task automatic test_overflow();
      int bc; bit ds, dl; logic [15:0] ao; logic ov, eo, ri, ee;
      do_op(8'd255, 8'd255, 8'd254, bc, ds, dl, ao, ov, eo, ri, ee);
      n_checks++; if (ao !== 16'hFEFF) begin n_fail++; $display("FAIL ovf_max_a: got %h expected feff", ao); end
      n_checks++; if ({ov, eo, ri} !== 3'b100) begin n_fail++; $display("FAIL ovf_max_flags: got %b expected 100", {ov, eo, ri}); end
      do_op(8'd1, 8'd200, 8'd0, bc, ds, dl, ao, ov, eo, ri, ee);
      n_checks++; if (ao !== 16'd200) begin n_fail++; $display("FAIL ovf_small_a: got %0d expected 200", ao); end
      n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL ovf_small_ovf: got %0d expected 0", ov); end
   endtask

   task automatic test_zero_divisor();
      int bc; bit ds, dl; logic [15:0] ao; logic ov, eo, ri, ee;
      do_op(8'h37, 8'd0, 8'd5, bc, ds, dl, ao, ov, eo, ri, ee);
      n_checks++; if (ds !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %0d expected 1", ds); end
      n_checks++; if (ee !== 1'b1) begin n_fail++; $display("FAIL zero_e_early: got %0d expected 1", ee); end
      n_checks++; if (ao !== 16'd5) begin n_fail++; $display("FAIL zero_a: got %0d expected 5", ao); end
      n_checks++; if ({ov, eo, ri} !== 3'b010) begin n_fail++; $display("FAIL zero_flags: got %b expected 010", {ov, eo, ri}); end
      do_op(8'd3, 8'd4, 8'd9, bc, ds, dl, ao, ov, eo, ri, ee);
      n_checks++; if (ao !== 16'd21) begin n_fail++; $display("FAIL rinv_a: got %0d expected 21", ao); end
      n_checks++; if ({ov, eo, ri} !== 3'b001) begin n_fail++; $display("FAIL rinv_flags: got %b expected 001", {ov, eo, ri}); end
   endtask

   task automatic test_back_to_back();
      int dones;
      dones = 0;
      @(negedge clk);
      q = 8'd2; b = 8'd3; r = 8'd1; start = 1'b1;   // accepted at the next edge k
      // Negedge n follows edge k+n-1; done expected at n=9 and n=18.
      for (int n = 1; n <= 19; n++) begin
         @(negedge clk);
         if (done) begin
            dones++;
            n_dones++;
            n_checks++; if (a !== 16'd7) begin n_fail++; $display("FAIL b2b_a: got %0d expected 7 at n=%0d", a, n); end
         end
         n_checks++;
         if (done !== ((n == 9) || (n == 18))) begin n_fail++; $display("FAIL b2b_done_timing: got %0d at n=%0d", done, n); end
         n_checks++;
         if (busy !== ((n <= 8) || ((n >= 10) && (n <= 17)))) begin n_fail++; $display("FAIL b2b_busy_timing: got %0d at n=%0d", busy, n); end
         if (n == 18) start = 1'b0;
      end
      n_ops += 2;
      n_checks++; if (dones !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", dones); end
   endtask

   task automatic test_reset_mid();
      int bc; bit ds, dl; logic [15:0] ao; logic ov, eo, ri, ee;
      bit saw_done;
      saw_done = 1'b0;
      @(negedge clk);
      q = 8'd200; b = 8'd200; r = 8'd0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(negedge clk);   // inside the 4th CALC cycle
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (a !== 16'd0) begin n_fail++; $display("FAIL rstmid_a: got %0d expected 0", a); end
      n_checks++; if ({ovf, e, rinv, busy, done} !== 5'b00000) begin n_fail++; $display("FAIL rstmid_flags: got %b expected 00000", {ovf, e, rinv, busy, done}); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (done || busy) saw_done = 1'b1;
      end
      n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d expected 0", saw_done); end
      do_op(8'd200, 8'd200, 8'd0, bc, ds, dl, ao, ov, eo, ri, ee);
      n_checks++; if (ao !== 16'd40000) begin n_fail++; $display("FAIL rstmid_fresh_a: got %0d expected 40000", ao); end
      n_checks++; if (ov !== 1'b1) begin n_fail++; $display("FAIL rstmid_fresh_ovf: got %0d expected 1", ov); end
   endtask

   task automatic test_sweep();
      logic [7:0] vals [14];
      int bc; bit ds, dl; logic [15:0] ao; logic ov, eo, ri, ee;
      logic [7:0] rv;
      logic [15:0] exp_a;
      int bad;
      bad = 0;
      vals = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd15, 8'd16, 8'd85,
               8'd127, 8'd128, 8'd170, 8'd200, 8'd254, 8'd255};
      for (int i = 0; i < 14; i++) begin
         for (int j = 0; j < 14; j++) begin
            if ((vals[j] == 8'd0) || (((i + j) % 2) == 0)) rv = 8'd0;
            else rv = 8'($urandom_range(int'(vals[j]) - 1));
            exp_a = 16'(int'(vals[i]) * int'(vals[j]) + int'(rv));
            do_op(vals[i], vals[j], rv, bc, ds, dl, ao, ov, eo, ri, ee);
            n_checks++;
            if ((ds !== 1'b1) || (ao !== exp_a) || (ov !== (exp_a > 16'd255)) || (eo !== (vals[j] == 8'd0)) || (ri !== 1'b0)) begin
               n_fail++; bad++;
               if (bad < 10) $display("FAIL sweep q=%0d b=%0d r=%0d: got a=%0d ovf=%0d e=%0d rinv=%0d done=%0d expected a=%0d", vals[i], vals[j], rv, ao, ov, eo, ri, ds, exp_a);
            end
         end
      end
      n_checks++; if (n_dones !== n_ops) begin n_fail++; $display("FAIL sweep_done_count: got %0d dones expected %0d", n_dones, n_ops); end
   endtask

   initial begin
      n_checks = 0; n_fail = 0; n_ops = 0; n_dones = 0;
      rst_n = 1'b0; start = 1'b0; q = 8'd0; b = 8'd0; r = 8'd0;
      test_reset();
      test_basic();
      test_overflow();
      test_zero_divisor();
      test_back_to_back();
      test_reset_mid();
      n_ops = 0; n_dones = 0;
      test_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
